// File: rtl/dcache_dm_pkg.sv
// Shared types for the direct-mapped data cache: controller states, access sizes
// and the size decode used by both the cache and its lane aligner.
package mmu_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, WTHRU = 2'd2} dc_state_t;

  typedef enum {SZ_B, SZ_H, SZ_W} mem_size_t;

  // Word overrides halfword; neither flag means a byte access.
  function automatic mem_size_t size_of(input logic hwrd, input logic wrd);
    if (wrd) return SZ_W;
    if (hwrd) return SZ_H;
    return SZ_B;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: load lane select and extension, store replication,
// byte strobes and natural-alignment check.
module dmem_align
  import mmu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  mem_size_t   size_i,
  input  logic        rdu_i,
  input  logic [31:0] line_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        misalign_o
);

  logic [15:0] lane;

  always_comb begin
    lane        = 16'(line_word_i >> {addr_lo_i, 3'b000});
    rdata_o     = line_word_i;
    mem_wdata_o = wdata_i;
    wstrb_o     = 4'b1111;
    misalign_o  = 1'b0;
    case (size_i)
      SZ_B: begin
        rdata_o     = {{24{~rdu_i & lane[7]}}, lane[7:0]};
        mem_wdata_o = {4{wdata_i[7:0]}};
        wstrb_o     = 4'b0001 << addr_lo_i;
      end
      SZ_H: begin
        rdata_o     = {{16{~rdu_i & lane[15]}}, lane[15:0]};
        mem_wdata_o = {2{wdata_i[15:0]}};
        wstrb_o     = 4'b0011 << addr_lo_i;
        misalign_o  = addr_lo_i[0];
      end
      default: misalign_o = |addr_lo_i;
    endcase
  end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, read-allocate, write-through L1 data cache with word-wide line refill.
// state  | meaning: IDLE = accept/serve request, REFILL = fetch line beats, WTHRU = store on bus
module dcache_dm
  import mmu_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 64,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_wdata,
  input  logic              dmem_write,
  input  logic              dmem_read,
  input  logic              dmem_rdu,
  input  logic              dmem_hwrd,
  input  logic              dmem_wrd,
  input  logic              dmem_flush,
  output logic              dmem_drdy,
  output logic [31:0]       dmem_rdata,
  output logic              dmem_misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WPL    = LINE_BYTES / 4;
  localparam int BEAT_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int WIDX_W = OFF_W + IDX_W - 2;

  dc_state_t             state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q [NUM_LINES];
  logic [31:0]           data_q [NUM_LINES*WPL];

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WIDX_W-1:0]     req_widx;
  logic [ADDR_W-1:0]     refill_addr;
  logic                  hit;
  logic [31:0]           al_rdata, al_wdata;
  logic [3:0]            al_wstrb;
  logic                  al_misalign;

  logic                  tag_we, data_we;
  logic [WIDX_W-1:0]     data_widx;
  logic [31:0]           data_wdata;
  logic [3:0]            data_wmask;

  assign req_tag     = dmem_addr[ADDR_W-1 -: TAG_W];
  assign req_idx     = dmem_addr[OFF_W +: IDX_W];
  assign req_widx    = dmem_addr[2 +: WIDX_W];
  assign refill_addr = {dmem_addr[ADDR_W-1:OFF_W], OFF_W'(0)} + (ADDR_W'(beat_q) << 2);
  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  dmem_align u_align (
    .addr_lo_i   (dmem_addr[1:0]),
    .size_i      (size_of(dmem_hwrd, dmem_wrd)),
    .rdu_i       (dmem_rdu),
    .line_word_i (data_q[req_widx]),
    .wdata_i     (dmem_wdata),
    .rdata_o     (al_rdata),
    .mem_wdata_o (al_wdata),
    .wstrb_o     (al_wstrb),
    .misalign_o  (al_misalign)
  );

  assign dmem_rdata = al_rdata;
  assign mem_wdata  = al_wdata;
  assign mem_wstrb  = al_wstrb;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    flush_pend_d  = flush_pend_q;
    valid_d       = valid_q;
    tag_we        = 1'b0;
    data_we       = 1'b0;
    data_widx     = req_widx;
    data_wdata    = mem_rdata;
    data_wmask    = 4'b1111;
    dmem_drdy     = 1'b0;
    dmem_misalign = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = {dmem_addr[ADDR_W-1:2], 2'b00};
    unique case (state_q)
      IDLE: begin
        if (dmem_flush) begin
          valid_d = '0;
        end else if (dmem_write || dmem_read) begin
          if (al_misalign) begin
            dmem_drdy     = 1'b1;
            dmem_misalign = 1'b1;
          end else if (dmem_write) begin
            state_d = WTHRU;
          end else if (hit) begin
            dmem_drdy = 1'b1;
          end else begin
            state_d = REFILL;
            beat_d  = '0;
          end
        end
      end
      REFILL: begin
        mem_req   = 1'b1;
        mem_addr  = refill_addr;
        data_widx = refill_addr[2 +: WIDX_W];
        if (dmem_flush) flush_pend_d = 1'b1;
        if (mem_ack) begin
          data_we = 1'b1;
          if (beat_q == BEAT_W'(WPL - 1)) begin
            state_d = IDLE;
            // A flush seen during the fill wins: the new line never becomes valid.
            if (flush_pend_q || dmem_flush) begin
              valid_d      = '0;
              flush_pend_d = 1'b0;
            end else begin
              tag_we           = 1'b1;
              valid_d[req_idx] = 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WTHRU: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (dmem_flush) flush_pend_d = 1'b1;
        if (mem_ack) begin
          dmem_drdy  = 1'b1;
          state_d    = IDLE;
          data_we    = hit;
          data_wdata = al_wdata;
          data_wmask = al_wstrb;
          if (flush_pend_q || dmem_flush) begin
            valid_d      = '0;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[req_idx] <= req_tag;
    if (data_we) begin
      for (int k = 0; k < 4; k++) begin
        if (data_wmask[k]) data_q[data_widx][8*k +: 8] <= data_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed sequences, a load-lane table and
// randomized traffic checked against a flat byte-memory model.
module tb_dcache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_write, dmem_read, dmem_rdu, dmem_hwrd, dmem_wrd, dmem_flush;
  logic        dmem_drdy, dmem_misalign;
  logic [31:0] dmem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dcache_dm dut (
    .clk(clk), .rst(rst),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_write(dmem_write),
    .dmem_read(dmem_read), .dmem_rdu(dmem_rdu), .dmem_hwrd(dmem_hwrd), .dmem_wrd(dmem_wrd),
    .dmem_flush(dmem_flush), .dmem_drdy(dmem_drdy), .dmem_rdata(dmem_rdata),
    .dmem_misalign(dmem_misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Backing memory model and bus responder
  logic [31:0] mem_m [int unsigned];
  typedef struct {logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata;} beat_t;
  beat_t beats[$];
  int ack_delay = 2;
  int wait_cnt  = 0;
  logic [31:0] wr_tmp;

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem_m.exists(wa)) return mem_m[wa];
    return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        beats.push_back('{mem_addr, mem_we, mem_wstrb, mem_wdata});
        if (mem_we) begin
          wr_tmp = mem_rd(mem_addr);
          for (int k = 0; k < 4; k++) if (mem_wstrb[k]) wr_tmp[8*k +: 8] = mem_wdata[8*k +: 8];
          mem_m[mem_addr] = wr_tmp;
        end else begin
          mem_rdata = mem_rd(mem_addr);
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic u, input logic h, input logic w);
    logic [31:0] word;
    logic [31:0] v;
    int sh;
    word = mem_rd(a & 32'hFFFF_FFFC);
    sh   = int'(a[1:0]) * 8;
    if (w) return word;
    if (h) begin
      v = (word >> sh) & 32'h0000_FFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    v = (word >> sh) & 32'h0000_00FF;
    if (!u && v[7]) v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  task automatic cpu_op(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                        input logic u, input logic h, input logic w,
                        output logic [31:0] rd, output logic mis, output int cyc);
    @(posedge clk); #1;
    dmem_addr = a; dmem_wdata = wd; dmem_write = wr; dmem_read = ~wr;
    dmem_rdu = u; dmem_hwrd = h; dmem_wrd = w;
    cyc = 0; rd = '0; mis = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk); #2;
      if (dmem_drdy) begin
        cyc = i; rd = dmem_rdata; mis = dmem_misalign;
        break;
      end
    end
    @(posedge clk); #1;
    dmem_write = 1'b0; dmem_read = 1'b0;
    if (cyc == 0) begin
      n_checks++;
      $display("FAIL timeout: no drdy for addr 0x%08h within 200 cycles", a);
    end
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1; dmem_flush = 1'b1;
    @(posedge clk); #1; dmem_flush = 1'b0;
  endtask

  typedef struct {logic [31:0] addr; logic u; logic h; logic w; logic [31:0] rd; logic mis;} vec_t;
  vec_t tbl[10];

  logic [31:0] rd, a, wd;
  logic        mis, u, h, w, wr, exp_mis;
  int          cyc;

  initial begin
    tbl[0] = '{32'h103, 1'b0, 1'b0, 1'b0, 32'hFFFFFF80, 1'b0};
    tbl[1] = '{32'h103, 1'b1, 1'b0, 1'b0, 32'h00000080, 1'b0};
    tbl[2] = '{32'h102, 1'b0, 1'b1, 1'b0, 32'hFFFF80FF, 1'b0};
    tbl[3] = '{32'h100, 1'b1, 1'b1, 1'b0, 32'h00007F01, 1'b0};
    tbl[4] = '{32'h101, 1'b0, 1'b0, 1'b0, 32'h0000007F, 1'b0};
    tbl[5] = '{32'h102, 1'b1, 1'b1, 1'b0, 32'h000080FF, 1'b0};
    tbl[6] = '{32'h100, 1'b0, 1'b0, 1'b1, 32'h80FF7F01, 1'b0};
    tbl[7] = '{32'h101, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
    tbl[8] = '{32'h102, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1};
    tbl[9] = '{32'h103, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1};

    mem_m[32'h100] = 32'h80FF7F01;
    dmem_addr = '0; dmem_wdata = '0; dmem_write = 0; dmem_read = 0;
    dmem_rdu = 0; dmem_hwrd = 0; dmem_wrd = 0; dmem_flush = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_drdy", dmem_drdy, 0);
    check("rst_misalign", dmem_misalign, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    rst = 1'b0;

    // Cold miss: 4 beats, 1 miss cycle + 4*(2 wait + 1 ack) + 1 hit cycle
    beats.delete();
    cpu_op(32'h100, 0, 0, 0, 0, 1, rd, mis, cyc);
    check("miss_cycles", cyc, 14);
    check("miss_beats", beats.size(), 4);
    foreach (beats[i]) begin
      check("miss_beat_addr", beats[i].addr, 32'h100 + 4 * i);
      check("miss_beat_we", beats[i].we, 0);
    end
    check("miss_rdata", rd, 32'h80FF7F01);

    beats.delete();
    cpu_op(32'h104, 0, 0, 0, 0, 1, rd, mis, cyc);
    check("hit_cycles", cyc, 1);
    check("hit_beats", beats.size(), 0);
    check("hit_rdata", rd, mem_rd(32'h104));

    beats.delete();
    foreach (tbl[i]) begin
      cpu_op(tbl[i].addr, 0, 0, tbl[i].u, tbl[i].h, tbl[i].w, rd, mis, cyc);
      check($sformatf("tbl%0d_mis", i), mis, tbl[i].mis);
      if (!tbl[i].mis) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      check($sformatf("tbl%0d_cycles", i), cyc, 1);
    end
    check("tbl_no_bus", beats.size(), 0);

    // Byte store on a cached line
    beats.delete();
    cpu_op(32'h101, 32'h000000AB, 1, 0, 0, 0, rd, mis, cyc);
    check("sb_cycles", cyc, 4);
    check("sb_beats", beats.size(), 1);
    if (beats.size() == 1) begin
      check("sb_addr", beats[0].addr, 32'h100);
      check("sb_we", beats[0].we, 1);
      check("sb_wstrb", beats[0].strb, 4'b0010);
      check("sb_wdata", beats[0].wdata, 32'hABABABAB);
    end
    cpu_op(32'h100, 0, 0, 0, 0, 1, rd, mis, cyc);
    check("sb_after_lw", rd, 32'h80FFAB01);
    check("sb_after_cycles", cyc, 1);

    beats.delete();
    cpu_op(32'h102, 32'h12345678, 1, 0, 0, 1, rd, mis, cyc);
    check("sw_mis", mis, 1);
    check("sw_mis_cycles", cyc, 1);
    check("sw_mis_bus", beats.size(), 0);

    pulse_flush();
    beats.delete();
    cpu_op(32'h104, 0, 0, 0, 0, 1, rd, mis, cyc);
    check("flush_beats", beats.size(), 4);
    if (beats.size() == 4) check("flush_base", beats[0].addr, 32'h100);
    check("flush_rdata", rd, mem_rd(32'h104));

    // Flush arriving mid-refill leaves the line invalid -> second fill
    beats.delete();
    fork
      cpu_op(32'h200, 0, 0, 0, 0, 1, rd, mis, cyc);
      begin
        repeat (4) @(posedge clk);
        #1 dmem_flush = 1'b1;
        @(posedge clk);
        #1 dmem_flush = 1'b0;
      end
    join
    check("flush_mid_beats", beats.size(), 8);
    check("flush_mid_rdata", rd, mem_rd(32'h200));
    beats.delete();
    cpu_op(32'h200, 0, 0, 0, 0, 1, rd, mis, cyc);
    check("flush_mid_rehit", cyc, 1);

    // Async reset during beat 2 of a refill
    beats.delete();
    @(posedge clk); #1;
    dmem_addr = 32'h300; dmem_read = 1; dmem_wrd = 1; dmem_hwrd = 0; dmem_rdu = 0;
    for (int i = 0; i < 100 && beats.size() < 1; i++) begin
      @(negedge clk); #2;
    end
    @(posedge clk); #1;
    check("rst_mid_req_before", mem_req, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_req_drop", mem_req, 0);
    dmem_read = 0;
    #4 rst = 1'b0;
    beats.delete();
    cpu_op(32'h300, 0, 0, 0, 0, 1, rd, mis, cyc);
    check("rst_mid_refill_beats", beats.size(), 4);
    check("rst_mid_cycles", cyc, 14);
    check("rst_mid_rdata", rd, mem_rd(32'h300));

    // Randomized traffic against the memory model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) pulse_flush();
      ack_delay = $urandom_range(0, 2);
      a  = 32'($urandom_range(0, 32'hFFF));
      wd = $urandom;
      wr = ($urandom_range(0, 9) < 4);
      u  = $urandom_range(0, 1);
      w  = ($urandom_range(0, 2) == 0);
      h  = $urandom_range(0, 1);
      exp_mis = (w && a[1:0] != 2'b00) || (!w && h && a[0]);
      beats.delete();
      cpu_op(a, wd, wr, u, h, w, rd, mis, cyc);
      check("rnd_mis", mis, exp_mis);
      if (exp_mis) begin
        check("rnd_mis_bus", beats.size(), 0);
      end else if (!wr) begin
        check("rnd_load", rd, exp_load(a, u, h, w));
      end else begin
        check("rnd_store_beats", beats.size(), 1);
        if (beats.size() == 1) begin
          logic [3:0]  es;
          logic [31:0] ed, m;
          if (w) begin
            es = 4'hF; ed = wd;
          end else if (h) begin
            es = 4'(3 << a[1:0]); ed = {16'h0, wd[15:0]} * 32'h00010001;
          end else begin
            es = 4'(1 << a[1:0]); ed = {24'h0, wd[7:0]} * 32'h01010101;
          end
          m = {{8{es[3]}}, {8{es[2]}}, {8{es[1]}}, {8{es[0]}}};
          check("rnd_store_addr", beats[0].addr, a & 32'hFFFF_FFFC);
          check("rnd_store_strb", beats[0].strb, es);
          check("rnd_store_data", beats[0].wdata & m, ed & m);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
